// File: rtl/uart_seq_pkg.sv
// uart_seq_pkg: FSM state encoding, default terminator byte and a width helper
// shared by the UART message sequencer.
package uart_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        LOAD  = 3'd4,
        FIN   = 3'd5
    } seq_state_t;

    localparam logic [7:0] TERM_DEFAULT = 8'h00;

    // Smallest r with 2**r >= n; used to size the byte counter.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_msg_seq.sv
// uart_tx_msg_seq: streams a message from RAM into a UART transmitter, stopping at TERM or MAX_LEN.
// Optional macro UART_TX_MSG_SEQ_ABORT_EN adds an abort input that ends the message early.
module uart_tx_msg_seq
    import uart_seq_pkg::*;
#(
    parameter int          ADDR_W  = 8,
    parameter int          MAX_LEN = 64,
    parameter logic [7:0]  TERM    = TERM_DEFAULT,
    localparam int         CNT_W   = clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
`ifdef UART_TX_MSG_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    input  logic              tx_rdy,
    output logic              tx_load,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_byte;
    logic [7:0]        r_tx_data;
    logic [CNT_W-1:0]  r_count;
    logic              r_mem_rd;
    logic              r_tx_load;
    logic              r_busy;
    logic              r_done;

`ifdef UART_TX_MSG_SEQ_ABORT_EN
    logic r_abort_pend;
    logic w_abort;

    // An abort seen during LOAD is remembered so it takes effect in the following FETCH.
    assign w_abort = abort | r_abort_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_abort_pend <= 1'b0;
        end else begin
            r_abort_pend <= (r_state == LOAD) & abort;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = FETCH;
            FETCH:   w_state_next = LATCH;
            LATCH:   w_state_next = (mem_data == TERM) ? FIN : SEND;
            SEND:    if (tx_rdy) w_state_next = LOAD;
            LOAD:    w_state_next = (r_count == LAST_CNT) ? FIN : FETCH;
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
`ifdef UART_TX_MSG_SEQ_ABORT_EN
        if (w_abort && (r_state == FETCH || r_state == LATCH || r_state == SEND)) begin
            w_state_next = FIN;
        end
`endif
    end

    // Strobes are decoded from the next state so they are registered yet line up with their state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_rd  <= 1'b0;
            r_tx_load <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_addr    <= '0;
            r_count   <= '0;
            r_byte    <= 8'h00;
            r_tx_data <= 8'h00;
        end else begin
            r_mem_rd  <= (w_state_next == FETCH);
            r_tx_load <= (w_state_next == LOAD);
            r_busy    <= (w_state_next != IDLE);
            r_done    <= (w_state_next == FIN);

            if (r_state == IDLE && start) begin
                r_addr  <= base_addr;
                r_count <= '0;
            end

            if (r_state == LATCH) begin
                r_byte <= mem_data;
            end

            if (w_state_next == LOAD) begin
                r_tx_data <= r_byte;
            end

            if (r_state == LOAD) begin
                r_count <= r_count + CNT_W'(1);
                r_addr  <= r_addr + ADDR_W'(1);
            end
        end
    end

    assign mem_rd   = r_mem_rd;
    assign mem_addr = r_addr;
    assign tx_load  = r_tx_load;
    assign tx_data  = r_tx_data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign count    = r_count;

endmodule
